// File: rtl/song_player_pkg.sv
// Shared widths, FSM state encoding and the note-length rule for the song player.
package song_pkg;

  localparam int IDX_W  = 21;
  localparam int OCT_W  = 3;
  localparam int NOTE_W = 3;
  localparam int LEN_W  = 4;
  localparam int FN_W   = 3;
  localparam int MAX_FN = 4;
  localparam int SONG_W = 3;
  localparam int DUR_W  = 9;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
    PAUSED,
    DONE
  } state_t;

  // Ticks = (length+1) << (4-fn), with fn saturated at MAX_FN: 1..256.
  function automatic logic [DUR_W-1:0] note_ticks(input logic [LEN_W-1:0] len,
                                                  input logic [FN_W-1:0]  fn);
    int                 fn_c;
    logic [DUR_W-1:0]   base;
    fn_c = (int'(fn) > MAX_FN) ? MAX_FN : int'(fn);
    base = DUR_W'(len) + DUR_W'(1);
    return base << (MAX_FN - fn_c);
  endfunction

endpackage

// File: rtl/song_player_if.sv
// Song ROM lookup bus: the player drives selection and index, the ROM answers combinationally.
interface song_player_if;
  import song_pkg::*;

  logic [SONG_W-1:0] rom_song;
  logic [IDX_W-1:0]  rom_cnt;
  logic [IDX_W-1:0]  rom_track;
  logic [OCT_W-1:0]  rom_octave;
  logic [NOTE_W-1:0] rom_note;
  logic [LEN_W-1:0]  rom_length;
  logic [FN_W-1:0]   rom_full_note;

  modport master (
    output rom_song, rom_cnt,
    input  rom_track, rom_octave, rom_note, rom_length, rom_full_note
  );

  modport slave (
    input  rom_song, rom_cnt,
    output rom_track, rom_octave, rom_note, rom_length, rom_full_note
  );

endinterface

// File: rtl/song_player_note_timer.sv
// Tick divider plus note-duration countdown; flags the final cycle and the articulation gap.
module note_timer
  import song_pkg::*;
#(
  parameter int TICK_CYCLES = 6_250_000,
  parameter int GAP_CYCLES  = 500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [DUR_W-1:0] load_ticks,
  input  logic             run,
  output logic             ending,
  output logic             gap
);

  localparam int             TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0]  GAP_START = TW'(TICK_CYCLES - GAP_CYCLES);

  logic [TW-1:0]    tick_reg, tick_next;
  logic [DUR_W-1:0] dur_reg, dur_next;
  logic             tick_wrap;
  logic             last_tick;

  assign tick_wrap = (tick_reg == TICK_LAST);
  assign last_tick = (dur_reg == DUR_W'(1));
  assign ending    = last_tick && tick_wrap;
  // The gap always falls inside the last tick because GAP_CYCLES < TICK_CYCLES.
  assign gap       = (GAP_CYCLES > 0) && last_tick && (tick_reg >= GAP_START);

  always_comb begin
    tick_next = tick_reg;
    dur_next  = dur_reg;
    if (clear) begin
      tick_next = '0;
      dur_next  = '0;
    end else if (load) begin
      tick_next = '0;
      dur_next  = load_ticks;
    end else if (run) begin
      if (tick_wrap) begin
        tick_next = '0;
        if (dur_reg != '0) dur_next = dur_reg - DUR_W'(1);
      end else begin
        tick_next = tick_reg + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_reg <= '0;
      dur_reg  <= '0;
    end else begin
      tick_reg <= tick_next;
      dur_reg  <= dur_next;
    end
  end

endmodule

// File: rtl/song_player.sv
// Steps through a song ROM note by note, driving a buzzer tone with per-note articulation gaps.
module song_player
  import song_pkg::*;
#(
  parameter int TICK_CYCLES = 6_250_000,
  parameter int GAP_CYCLES  = 500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  input  logic [SONG_W-1:0] song_sel,
  song_player_if.master     rom,
  output logic              tone_valid,
  output logic [OCT_W-1:0]  tone_octave,
  output logic [NOTE_W-1:0] tone_note,
  output logic              playing,
  output logic              done,
  output logic [IDX_W-1:0]  note_idx
);

  state_t            state_reg, state_next;
  logic [SONG_W-1:0] song_reg, song_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [OCT_W-1:0]  oct_reg, oct_next;
  logic [NOTE_W-1:0] note_reg, note_next;

  logic tmr_clear, tmr_load, tmr_run, tmr_ending, tmr_gap;
  logic last_note;

  // One extra bit so an index at the top of the range cannot wrap into a false match.
  assign last_note = ({1'b0, idx_reg} + (IDX_W+1)'(1)) == {1'b0, rom.rom_track};

  note_timer #(
    .TICK_CYCLES (TICK_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (tmr_clear),
    .load       (tmr_load),
    .load_ticks (note_ticks(rom.rom_length, rom.rom_full_note)),
    .run        (tmr_run),
    .ending     (tmr_ending),
    .gap        (tmr_gap)
  );

  always_comb begin
    state_next = state_reg;
    song_next  = song_reg;
    idx_next   = idx_reg;
    oct_next   = oct_reg;
    note_next  = note_reg;
    tmr_clear  = 1'b0;
    tmr_load   = 1'b0;
    tmr_run    = 1'b0;
    if (stop) begin
      state_next = IDLE;
      idx_next   = '0;
      tmr_clear  = 1'b1;
    end else if (start) begin
      state_next = FETCH;
      song_next  = song_sel;
      idx_next   = '0;
      tmr_clear  = 1'b1;
    end else begin
      case (state_reg)
        FETCH: begin
          if (rom.rom_track == '0) begin
            state_next = DONE;
          end else begin
            oct_next   = rom.rom_octave;
            note_next  = rom.rom_note;
            tmr_load   = 1'b1;
            state_next = PLAY;
          end
        end
        PLAY: begin
          // The cycle that sees pause still advances; only PAUSED freezes the counters.
          tmr_run = 1'b1;
          if (tmr_ending) begin
            if (!last_note) begin
              idx_next   = idx_reg + IDX_W'(1);
              state_next = FETCH;
            end else if (loop) begin
              idx_next   = '0;
              state_next = FETCH;
            end else begin
              state_next = DONE;
            end
          end else if (pause) begin
            state_next = PAUSED;
          end
        end
        PAUSED: if (!pause) state_next = PLAY;
        DONE:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      song_reg  <= '0;
      idx_reg   <= '0;
      oct_reg   <= '0;
      note_reg  <= '0;
    end else begin
      state_reg <= state_next;
      song_reg  <= song_next;
      idx_reg   <= idx_next;
      oct_reg   <= oct_next;
      note_reg  <= note_next;
    end
  end

  assign rom.rom_song = song_reg;
  assign rom.rom_cnt  = idx_reg;
  assign tone_valid   = (state_reg == PLAY) && !tmr_gap;
  assign tone_octave  = oct_reg;
  assign tone_note    = note_reg;
  assign playing      = (state_reg == FETCH) || (state_reg == PLAY) || (state_reg == PAUSED);
  assign done         = (state_reg == DONE);
  assign note_idx     = idx_reg;

endmodule

// File: tb/tb_song_player.sv
// Randomized self-checking bench: a per-cycle expected trace is built from the song table.
module tb_song_player;
  import song_pkg::*;

  localparam int TICK = 4;
  localparam int GAP  = 1;

  logic        clk = 1'b0;
  logic        rst, start, stop, pause, loop;
  logic [2:0]  song_sel;
  logic        tone_valid, playing, done;
  logic [2:0]  tone_octave, tone_note;
  logic [20:0] note_idx;

  song_player_if rom_bus();

  song_player #(.TICK_CYCLES(TICK), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop(loop),
    .song_sel(song_sel), .rom(rom_bus), .tone_valid(tone_valid), .tone_octave(tone_octave),
    .tone_note(tone_note), .playing(playing), .done(done), .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  // Song ROM model: up to 4 notes per song.
  logic [20:0] trk   [8];
  logic [2:0]  oct_t [8][4];
  logic [2:0]  nt_t  [8][4];
  logic [3:0]  len_t [8][4];
  logic [2:0]  fn_t  [8][4];

  assign rom_bus.rom_track     = trk[rom_bus.rom_song];
  assign rom_bus.rom_octave    = oct_t[rom_bus.rom_song][rom_bus.rom_cnt[1:0]];
  assign rom_bus.rom_note      = nt_t[rom_bus.rom_song][rom_bus.rom_cnt[1:0]];
  assign rom_bus.rom_length    = len_t[rom_bus.rom_song][rom_bus.rom_cnt[1:0]];
  assign rom_bus.rom_full_note = fn_t[rom_bus.rom_song][rom_bus.rom_cnt[1:0]];

  typedef struct {
    logic        tv, pl, dn, ci, ct;
    logic [20:0] idx;
    logic [2:0]  oct, nt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(bit tv, bit pl, bit dn, bit ci, bit ct, int idx, logic [2:0] o, logic [2:0] n);
    exp_t e;
    e.tv = tv; e.pl = pl; e.dn = dn; e.ci = ci; e.ct = ct;
    e.idx = 21'(idx); e.oct = o; e.nt = n;
    return e;
  endfunction

  function automatic void set_note(int s, int i, int o, int n, int l, int f);
    oct_t[s][i] = 3'(o); nt_t[s][i] = 3'(n); len_t[s][i] = 4'(l); fn_t[s][i] = 3'(f);
  endfunction

  function automatic void random_song(int s, int notes);
    trk[s] = 21'(notes);
    for (int i = 0; i < 4; i++)
      set_note(s, i, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7));
  endfunction

  // Expected trace, entry k = k-th cycle after the start edge: a silent fetch cycle per note,
  // then duration*TICK play cycles whose last GAP are silent, then a done pulse and idle.
  function automatic void model_song(int s, bit loop_on, int max_len);
    int n, fc, cyc;
    exp_q.delete();
    if (trk[s] == 0) begin
      exp_q.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      return;
    end
    n = 0;
    while (exp_q.size() < max_len) begin
      exp_q.push_back(mk(0, 1, 0, 1, 0, n, 0, 0));
      fc  = (fn_t[s][n] > 4) ? 4 : int'(fn_t[s][n]);
      cyc = (int'(len_t[s][n]) + 1) * (1 << (4 - fc)) * TICK;
      for (int c = 0; c < cyc; c++)
        exp_q.push_back(mk(c < cyc - GAP, 1, 0, 1, 1, n, oct_t[s][n], nt_t[s][n]));
      n++;
      if (n == int'(trk[s])) begin
        if (loop_on) n = 0;
        else begin
          exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
          exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
          break;
        end
      end
    end
  endfunction

  task automatic kick(int s);
    song_sel = 3'(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; song_sel = 3'd5;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({tone_valid, playing, done, tone_octave, tone_note} !== 9'd0 || note_idx !== 21'd0 ||
          rom_bus.rom_song !== 3'd0 || dut.state_reg !== IDLE) begin
        errors++;
        $display("FAIL reset tv=%b pl=%b dn=%b oct=%0d nt=%0d idx=%0d song=%0d state=%0d required all zero/IDLE",
                 tone_valid, playing, done, tone_octave, tone_note, note_idx, rom_bus.rom_song, dut.state_reg);
      end
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (playing !== 1'b0 || dut.state_reg !== IDLE) begin
      errors++;
      $display("FAIL reset_start pl=%b state=%0d required pl=0 state=IDLE", playing, dut.state_reg);
    end
    trk[1] = 21'd2; set_note(1, 0, 5, 6, 1, 2); set_note(1, 1, 3, 2, 0, 4);
    kick(1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({tone_valid, playing, done, tone_octave, tone_note} !== 9'd0 || note_idx !== 21'd0 ||
        rom_bus.rom_song !== 3'd0 || dut.state_reg !== IDLE) begin
      errors++;
      $display("FAIL reset_mid tv=%b pl=%b oct=%0d nt=%0d song=%0d state=%0d required all zero/IDLE",
               tone_valid, playing, tone_octave, tone_note, rom_bus.rom_song, dut.state_reg);
    end
    $display("reset: idle after rst, rst+start and rst mid-note");
  endtask

  task automatic test_two_notes();
    exp_t e;
    trk[1] = 21'd2; set_note(1, 0, 3, 1, 0, 4); set_note(1, 1, 4, 2, 0, 4);
    model_song(1, 0, 1000);
    kick(1);
    foreach (exp_q[k]) begin
      e = exp_q[k]; checks++;
      if (tone_valid !== e.tv || playing !== e.pl || done !== e.dn || rom_bus.rom_song !== 3'd1 ||
          (e.ci && note_idx !== e.idx) || (e.ct && {tone_octave, tone_note} !== {e.oct, e.nt})) begin
        errors++;
        $display("FAIL two_notes cyc=%0d got tv=%b pl=%b dn=%b idx=%0d oct=%0d nt=%0d required tv=%b pl=%b dn=%b idx=%0d oct=%0d nt=%0d",
                 k + 1, tone_valid, playing, done, note_idx, tone_octave, tone_note, e.tv, e.pl, e.dn, e.idx, e.oct, e.nt);
      end
      @(negedge clk);
    end
    $display("two_notes: song 1, %0d cycles", exp_q.size());
  endtask

  task automatic test_durations();
    exp_t e;
    trk[2] = 21'd2; set_note(2, 0, 6, 4, 1, 3); set_note(2, 1, 2, 7, 0, 7);
    model_song(2, 0, 1000);
    kick(2);
    foreach (exp_q[k]) begin
      e = exp_q[k]; checks++;
      if (tone_valid !== e.tv || playing !== e.pl || done !== e.dn || rom_bus.rom_song !== 3'd2 ||
          (e.ci && note_idx !== e.idx) || (e.ct && {tone_octave, tone_note} !== {e.oct, e.nt})) begin
        errors++;
        $display("FAIL durations cyc=%0d got tv=%b pl=%b dn=%b idx=%0d required tv=%b pl=%b dn=%b idx=%0d",
                 k + 1, tone_valid, playing, done, note_idx, e.tv, e.pl, e.dn, e.idx);
      end
      @(negedge clk);
    end
    $display("durations: song 2, %0d cycles", exp_q.size());
  endtask

  task automatic test_empty();
    exp_t e;
    trk[0] = 21'd0;
    model_song(0, 0, 1000);
    kick(0);
    foreach (exp_q[k]) begin
      e = exp_q[k]; checks++;
      if (tone_valid !== e.tv || playing !== e.pl || done !== e.dn || rom_bus.rom_song !== 3'd0 ||
          (e.ci && note_idx !== e.idx)) begin
        errors++;
        $display("FAIL empty cyc=%0d got tv=%b pl=%b dn=%b required tv=%b pl=%b dn=%b",
                 k + 1, tone_valid, playing, done, e.tv, e.pl, e.dn);
      end
      @(negedge clk);
    end
    $display("empty: song 0, %0d cycles", exp_q.size());
  endtask

  task automatic test_pause();
    exp_t e;
    int   p;
    random_song(3, $urandom_range(1, 2));
    set_note(3, 0, 5, 3, 1, 2);
    p = $urandom_range(1, 26);
    model_song(3, 0, 1000);
    for (int i = 0; i < 5; i++) exp_q.insert(p + 1, mk(0, 1, 0, 1, 1, 0, 3'd5, 3'd3));
    kick(3);
    foreach (exp_q[k]) begin
      e = exp_q[k]; checks++;
      if (tone_valid !== e.tv || playing !== e.pl || done !== e.dn || rom_bus.rom_song !== 3'd3 ||
          (e.ci && note_idx !== e.idx) || (e.ct && {tone_octave, tone_note} !== {e.oct, e.nt})) begin
        errors++;
        $display("FAIL pause cyc=%0d p=%0d got tv=%b pl=%b dn=%b idx=%0d required tv=%b pl=%b dn=%b idx=%0d",
                 k + 1, p, tone_valid, playing, done, note_idx, e.tv, e.pl, e.dn, e.idx);
      end
      pause = (k >= p && k < p + 5);
      @(negedge clk);
    end
    pause = 1'b0;
    $display("pause: song 3, pause at %0d, %0d cycles", p, exp_q.size());
  endtask

  task automatic test_loop_stop();
    exp_t e;
    trk[4] = 21'd2; set_note(4, 0, 1, 1, 0, 4); set_note(4, 1, 2, 2, 0, 4);
    loop = 1'b1;
    model_song(4, 1, 20);
    kick(4);
    for (int k = 0; k < 18; k++) begin
      e = exp_q[k]; checks++;
      if (tone_valid !== e.tv || playing !== e.pl || done !== e.dn || rom_bus.rom_song !== 3'd4 ||
          (e.ci && note_idx !== e.idx)) begin
        errors++;
        $display("FAIL loop cyc=%0d got tv=%b pl=%b dn=%b idx=%0d required tv=%b pl=%b dn=%b idx=%0d",
                 k + 1, tone_valid, playing, done, note_idx, e.tv, e.pl, e.dn, e.idx);
      end
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; loop = 1'b0;
    checks++;
    if (tone_valid !== 1'b0 || playing !== 1'b0 || done !== 1'b0 || note_idx !== 21'd0 || dut.state_reg !== IDLE) begin
      errors++;
      $display("FAIL stop got tv=%b pl=%b dn=%b idx=%0d state=%0d required 0/0/0/0/IDLE",
               tone_valid, playing, done, note_idx, dut.state_reg);
    end
    $display("loop_stop: song 4 looped, stopped mid-note");
  endtask

  task automatic test_restart();
    exp_t e;
    trk[5] = 21'd2; set_note(5, 0, 7, 7, 1, 2); set_note(5, 1, 1, 1, 1, 2);
    random_song(6, $urandom_range(1, 3));
    model_song(5, 0, 1000);
    kick(5);
    for (int k = 0; k < 10; k++) begin
      e = exp_q[k]; checks++;
      if (tone_valid !== e.tv || playing !== e.pl || rom_bus.rom_song !== 3'd5 || (e.ci && note_idx !== e.idx)) begin
        errors++;
        $display("FAIL restart_pre cyc=%0d got tv=%b pl=%b idx=%0d required tv=%b pl=%b idx=%0d",
                 k + 1, tone_valid, playing, note_idx, e.tv, e.pl, e.idx);
      end
      @(negedge clk);
    end
    model_song(6, 0, 1000);
    kick(6);
    foreach (exp_q[k]) begin
      e = exp_q[k]; checks++;
      if (tone_valid !== e.tv || playing !== e.pl || done !== e.dn || rom_bus.rom_song !== 3'd6 ||
          (e.ci && note_idx !== e.idx) || (e.ct && {tone_octave, tone_note} !== {e.oct, e.nt})) begin
        errors++;
        $display("FAIL restart cyc=%0d got tv=%b pl=%b dn=%b idx=%0d song=%0d required tv=%b pl=%b dn=%b idx=%0d song=6",
                 k + 1, tone_valid, playing, done, note_idx, rom_bus.rom_song, e.tv, e.pl, e.dn, e.idx);
      end
      @(negedge clk);
    end
    $display("restart: song 5 interrupted by song 6, %0d cycles", exp_q.size());
  endtask

  task automatic test_random();
    exp_t e;
    int   s;
    repeat (6) begin
      s = $urandom_range(0, 7);
      random_song(s, $urandom_range(0, 3));
      model_song(s, 0, 2000);
      kick(s);
      foreach (exp_q[k]) begin
        e = exp_q[k]; checks++;
        if (tone_valid !== e.tv || playing !== e.pl || done !== e.dn || rom_bus.rom_song !== 3'(s) ||
            (e.ci && note_idx !== e.idx) || (e.ct && {tone_octave, tone_note} !== {e.oct, e.nt})) begin
          errors++;
          $display("FAIL random song=%0d cyc=%0d got tv=%b pl=%b dn=%b idx=%0d oct=%0d nt=%0d required tv=%b pl=%b dn=%b idx=%0d oct=%0d nt=%0d",
                   s, k + 1, tone_valid, playing, done, note_idx, tone_octave, tone_note, e.tv, e.pl, e.dn, e.idx, e.oct, e.nt);
        end
        @(negedge clk);
      end
      $display("random: song %0d, %0d notes, %0d cycles", s, trk[s], exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0; song_sel = 3'd0;
    for (int s = 0; s < 8; s++) begin
      trk[s] = 21'd0;
      for (int i = 0; i < 4; i++) set_note(s, i, 0, 0, 0, 0);
    end
    test_reset();
    test_two_notes();
    test_durations();
    test_empty();
    test_pause();
    test_loop_stop();
    test_restart();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
